// File: rtl/fifo_pkg.sv
// Shared definitions for the 64x8 byte FIFO and its read-side word packer.
package fifo_pkg;
  localparam int FIFO_DW      = 8;
  localparam int FIFO_DEPTH   = 64;
  localparam int PACK_DEFAULT = 4;

  typedef enum logic [1:0] {RUN, FLUSH_WAIT, FLUSH_EMIT} rd_pack_state_t;
endpackage

// File: rtl/FIFO64x8.sv
// 64-entry byte FIFO with registered read data (valid the cycle after a pop).
module FIFO64x8
  import fifo_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [FIFO_DW-1:0]            data_i,
  input  logic                          rd_en,
  output logic [FIFO_DW-1:0]            data_o,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic [AW:0]        cnt_q;
  logic               do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign count = cnt_q;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt_q  <= '0;
      data_o <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        data_o <= mem[rptr];
        rptr   <= rptr + 1'b1;
      end
      cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the byte FIFO and packs bytes little-endian into PACK-lane words,
// with a flush that emits any partial word under a keep mask.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DW   = FIFO_DW,
  parameter int PACK = PACK_DEFAULT
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [DW-1:0]      fifo_data,
  input  logic               flush,
  output logic [DW*PACK-1:0] word_o,
  output logic [PACK-1:0]    word_keep,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               flush_done
);
  localparam int CW = $clog2(PACK+1);
  localparam int WW = DW*PACK;

  rd_pack_state_t             state, state_nx;
  logic [PACK-1:0][DW-1:0]    acc, acc_land;
  logic [CW-1:0]              cnt, cnt_land;
  logic                       pend;
  logic                       out_free, full_move, part_move, flush_fin;
  logic [WW-1:0]              part_word;
  logic [PACK-1:0]            part_keep;

  // cnt + pend counts the byte still in flight so the pipe never over-pops.
  assign fifo_rd_en = reset_n && (state == RUN) && !fifo_empty &&
                      (({1'b0, cnt} + (CW+1)'(pend)) < (CW+1)'(PACK));

  always_comb begin
    acc_land = acc;
    for (int i = 0; i < PACK; i++)
      if (pend && (cnt == CW'(i))) acc_land[i] = fifo_data;
    cnt_land = cnt + CW'(pend);
  end

  assign out_free  = !word_valid || word_ready;
  assign full_move = (cnt_land == CW'(PACK)) && out_free;

  always_comb begin
    part_word = '0;
    part_keep = '0;
    for (int i = 0; i < PACK; i++)
      if (CW'(i) < cnt) begin
        part_word[i*DW +: DW] = acc[i];
        part_keep[i]          = 1'b1;
      end
  end

  always_comb begin
    state_nx  = state;
    part_move = 1'b0;
    flush_fin = 1'b0;
    case (state)
      RUN:        if (flush) state_nx = FLUSH_WAIT;
      // Drain the in-flight byte and any held full word before deciding.
      FLUSH_WAIT: if (!pend && (cnt != CW'(PACK))) begin
                    if (cnt == '0) begin
                      flush_fin = 1'b1;
                      state_nx  = RUN;
                    end else begin
                      state_nx  = FLUSH_EMIT;
                    end
                  end
      FLUSH_EMIT: if (out_free) begin
                    part_move = 1'b1;
                    flush_fin = 1'b1;
                    state_nx  = RUN;
                  end
      default:    state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      acc        <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      word_o     <= '0;
      word_keep  <= '0;
      word_valid <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nx;
      pend       <= fifo_rd_en;
      acc        <= acc_land;
      flush_done <= flush_fin;
      cnt        <= (full_move || part_move) ? '0 : cnt_land;
      if (full_move) begin
        word_o     <= acc_land;
        word_keep  <= '1;
        word_valid <= 1'b1;
      end else if (part_move) begin
        word_o     <= part_word;
        word_keep  <= part_keep;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// FIFO64x8 feeding fifo_rd_packer; directed and randomized scenarios against a byte-queue model.
module tb_fifo_rd_packer;
  import fifo_pkg::*;
  localparam int DW = 8, PACK = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        fifo_empty, fifo_full, fifo_rd_en;
  logic [6:0]  fifo_count;
  logic [7:0]  fifo_data;
  logic        flush = 1'b0, word_ready = 1'b0;
  logic [31:0] word_o;
  logic [3:0]  word_keep;
  logic        word_valid, flush_done;

  always #5 clk = ~clk;

  FIFO64x8 u_fifo (.clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_i(wr_data),
                   .rd_en(fifo_rd_en), .data_o(fifo_data), .empty(fifo_empty),
                   .full(fifo_full), .count(fifo_count));

  fifo_rd_packer #(.DW(DW), .PACK(PACK)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .flush(flush), .word_o(word_o), .word_keep(word_keep),
    .word_valid(word_valid), .word_ready(word_ready), .flush_done(flush_done));

  int errors = 0, checks = 0;
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  logic [7:0]  byte_q[$];
  int got_idx = 0;
  int rd_pulses = 0, rd_empty_viol = 0, fd_pulses = 0, wv_seen = 0, hold_viol = 0;
  logic [35:0] prev_w = '0;
  bit prev_hold = 0;

  // Observer: handshakes, pop pulses, flush_done pulses, hold stability.
  always @(negedge clk) begin
    if (!reset_n) prev_hold = 0;
    else begin
      if (prev_hold && (!word_valid || {word_o, word_keep} !== prev_w)) hold_viol++;
      prev_hold = word_valid && !word_ready;
      prev_w    = {word_o, word_keep};
      if (word_valid && word_ready) got_q.push_back({word_o, word_keep});
      if (fifo_rd_en) rd_pulses++;
      if (fifo_rd_en && fifo_empty) rd_empty_viol++;
      if (flush_done) fd_pulses++;
      if (word_valid) wv_seen++;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b; byte_q.push_back(b);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic get_word(output logic [35:0] w);
    if (got_idx < got_q.size()) begin w = got_q[got_idx]; got_idx++; end
    else w = 'x;
  endtask

  task automatic wait_idle(input int maxc, output bit timed_out);
    int q = 0;
    timed_out = 1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (fifo_empty && !word_valid && !fifo_rd_en) q++; else q = 0;
      if (q >= 4) begin timed_out = 0; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_flush_done(input int maxc, output bit seen);
    seen = 0;
    for (int c = 0; c < maxc && !seen; c++) begin
      @(negedge clk);
      if (flush_done) seen = 1;
    end
    @(posedge clk); #1;
  endtask

  // Model: bytes pop in FIFO order, four per word, lane 0 first; a flush emits the remainder.
  task automatic model_pack(input bit do_flush);
    logic [31:0] w; logic [3:0] k; int n;
    while (byte_q.size() >= PACK) begin
      w = '0;
      for (int i = 0; i < PACK; i++) w[8*i +: 8] = byte_q.pop_front();
      exp_q.push_back({w, 4'hF});
    end
    if (do_flush && byte_q.size() > 0) begin
      n = byte_q.size(); w = '0;
      for (int i = 0; i < n; i++) w[8*i +: 8] = byte_q.pop_front();
      k = 4'((1 << n) - 1);
      exp_q.push_back({w, k});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({word_o, word_keep, word_valid, flush_done} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {word_o, word_keep, word_valid, flush_done}); end
    checks++; if (fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    got_idx = got_q.size();
  endtask

  task automatic test_streaming();
    logic [35:0] w; bit to; int base = rd_pulses;
    word_ready = 1'b1; got_idx = got_q.size();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    wait_idle(100, to);
    byte_q.delete();
    checks++; if (to) begin errors++; $display("FAIL stream_timeout: got timeout want idle"); end
    get_word(w);
    checks++; if (w !== {32'h04030201, 4'hF}) begin errors++; $display("FAIL stream_w0: got %h want %h", w, {32'h04030201, 4'hF}); end
    get_word(w);
    checks++; if (w !== {32'h08070605, 4'hF}) begin errors++; $display("FAIL stream_w1: got %h want %h", w, {32'h08070605, 4'hF}); end
    checks++; if (got_q.size() != got_idx) begin errors++; $display("FAIL stream_extra: got %0d words want 0 extra", got_q.size() - got_idx); end
    checks++; if (rd_pulses - base != 8) begin errors++; $display("FAIL stream_pops: got %0d want 8", rd_pulses - base); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_backpressure();
    logic [35:0] w; bit to; int hbase = hold_viol;
    word_ready = 1'b0; got_idx = got_q.size();
    for (int i = 0; i < 12; i++) push_byte(8'(8'h10 + i));
    byte_q.delete();
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if ({word_valid, word_o, word_keep} !== {1'b1, 32'h13121110, 4'hF}) begin
      errors++; $display("FAIL bp_held: got %h want %h", {word_valid, word_o, word_keep}, {1'b1, 32'h13121110, 4'hF}); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (fifo_count !== 7'd4) begin errors++; $display("FAIL bp_fifo_left: got %0d want 4", fifo_count); end
    checks++; if (dut.cnt !== 3'd4) begin errors++; $display("FAIL bp_acc_full: got %0d want 4", dut.cnt); end
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait_idle(100, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: got timeout want idle"); end
    get_word(w);
    checks++; if (w !== {32'h13121110, 4'hF}) begin errors++; $display("FAIL bp_w0: got %h want %h", w, {32'h13121110, 4'hF}); end
    get_word(w);
    checks++; if (w !== {32'h17161514, 4'hF}) begin errors++; $display("FAIL bp_w1: got %h want %h", w, {32'h17161514, 4'hF}); end
    get_word(w);
    checks++; if (w !== {32'h1B1A1918, 4'hF}) begin errors++; $display("FAIL bp_w2: got %h want %h", w, {32'h1B1A1918, 4'hF}); end
    checks++; if (hold_viol != hbase) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", hold_viol - hbase); end
  endtask

  task automatic test_partial_flush();
    logic [35:0] w; bit to, seen; int fbase;
    word_ready = 1'b1; got_idx = got_q.size();
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    byte_q.delete();
    wait_idle(50, to);
    fbase = fd_pulses;
    pulse_flush();
    wait_flush_done(20, seen);
    wait_idle(50, to);
    checks++; if (!seen || to) begin errors++; $display("FAIL pflush_done: got seen=%b to=%b want seen=1 to=0", seen, to); end
    get_word(w);
    checks++; if (w !== {32'h00A3A2A1, 4'h7}) begin errors++; $display("FAIL pflush_word: got %h want %h", w, {32'h00A3A2A1, 4'h7}); end
    checks++; if (fd_pulses - fbase != 1) begin errors++; $display("FAIL pflush_pulses: got %0d want 1", fd_pulses - fbase); end
    checks++; if (got_q.size() != got_idx) begin errors++; $display("FAIL pflush_extra: got %0d extra want 0", got_q.size() - got_idx); end
  endtask

  task automatic test_empty_flush();
    bit seen = 0; int wbase = wv_seen, fbase = fd_pulses;
    pulse_flush();
    for (int c = 0; c < 2; c++) begin @(negedge clk); if (flush_done) seen = 1; end
    checks++; if (!seen) begin errors++; $display("FAIL eflush_done: got 0 want pulse within 2 cycles"); end
    repeat (5) @(posedge clk); #1;
    checks++; if (wv_seen != wbase) begin errors++; $display("FAIL eflush_valid: got %0d valid cycles want 0", wv_seen - wbase); end
    checks++; if (fd_pulses - fbase != 1) begin errors++; $display("FAIL eflush_pulses: got %0d want 1", fd_pulses - fbase); end
  endtask

  task automatic test_empty_gaps();
    logic [35:0] w; bit to; int vbase = rd_empty_viol;
    word_ready = 1'b1; got_idx = got_q.size();
    push_byte(8'h55);
    repeat (10) @(posedge clk); #1;
    push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
    byte_q.delete();
    wait_idle(50, to);
    checks++; if (to) begin errors++; $display("FAIL gaps_timeout: got timeout want idle"); end
    get_word(w);
    checks++; if (w !== {32'h88776655, 4'hF}) begin errors++; $display("FAIL gaps_word: got %h want %h", w, {32'h88776655, 4'hF}); end
    checks++; if (got_q.size() != got_idx) begin errors++; $display("FAIL gaps_extra: got %0d extra want 0", got_q.size() - got_idx); end
    checks++; if (rd_empty_viol != vbase) begin errors++; $display("FAIL gaps_pop_empty: got %0d want 0", rd_empty_viol - vbase); end
  endtask

  task automatic test_flush_on_last();
    logic [35:0] w; bit to, seen, hit = 0; int fbase = fd_pulses;
    word_ready = 1'b1; got_idx = got_q.size();
    fork
      begin
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC1 + i));
      end
      begin
        int n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin @(negedge clk); if (fifo_rd_en) n++; end
        hit = (n == 4);
        @(posedge clk); #1;
        pulse_flush();
      end
    join
    byte_q.delete();
    wait_flush_done(20, seen);
    wait_idle(50, to);
    checks++; if (!hit || !seen || to) begin errors++; $display("FAIL lastflush_seq: got hit=%b seen=%b to=%b want 1 1 0", hit, seen, to); end
    get_word(w);
    checks++; if (w !== {32'hC4C3C2C1, 4'hF}) begin errors++; $display("FAIL lastflush_word: got %h want %h", w, {32'hC4C3C2C1, 4'hF}); end
    checks++; if (got_q.size() != got_idx) begin errors++; $display("FAIL lastflush_extra: got %0d extra want 0", got_q.size() - got_idx); end
    checks++; if (fd_pulses - fbase != 1) begin errors++; $display("FAIL lastflush_pulses: got %0d want 1", fd_pulses - fbase); end
  endtask

  task automatic test_random();
    logic [35:0] w; bit to, seen; int n, q, hbase, vbase;
    for (int it = 0; it < 4; it++) begin
      hbase = hold_viol; vbase = rd_empty_viol;
      got_idx = got_q.size(); exp_q.delete(); byte_q.delete();
      n = $urandom_range(1, 14);
      for (int k = 0; k < n; k++) begin
        word_ready = 1'($urandom);
        push_byte(8'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; word_ready = 1'($urandom); end
      end
      q = 0;
      for (int c = 0; c < 300 && q < 3; c++) begin
        @(posedge clk); #1; word_ready = 1'($urandom);
        @(negedge clk); if (fifo_empty && !fifo_rd_en) q++; else q = 0;
      end
      @(posedge clk); #1;
      pulse_flush();
      word_ready = 1'b1;
      wait_flush_done(50, seen);
      wait_idle(100, to);
      checks++; if (q < 3 || !seen || to) begin errors++; $display("FAIL rand_progress: got q=%0d seen=%b to=%b", q, seen, to); end
      model_pack(1'b1);
      foreach (exp_q[i]) begin
        get_word(w);
        checks++; if (w !== exp_q[i]) begin errors++; $display("FAIL rand_word: it %0d idx %0d got %h want %h", it, i, w, exp_q[i]); end
      end
      checks++; if (got_q.size() != got_idx) begin errors++; $display("FAIL rand_extra: got %0d extra want 0", got_q.size() - got_idx); end
      checks++; if (hold_viol != hbase || rd_empty_viol != vbase) begin
        errors++; $display("FAIL rand_protocol: got hold=%0d pop_empty=%0d want 0 0", hold_viol - hbase, rd_empty_viol - vbase); end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] w; bit to;
    word_ready = 1'b1;
    push_byte(8'hB1); push_byte(8'hB2);
    repeat (4) @(posedge clk); #1;
    checks++; if (dut.cnt !== 3'd2) begin errors++; $display("FAIL rstmid_landed: got %0d want 2", dut.cnt); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if ({word_o, word_keep, word_valid, flush_done, fifo_rd_en} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0", {word_o, word_keep, word_valid, flush_done, fifo_rd_en}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    byte_q.delete();
    @(posedge clk); #1;
    got_idx = got_q.size();
    for (int i = 0; i < 4; i++) push_byte(8'(8'hD1 + i));
    byte_q.delete();
    wait_idle(50, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_timeout: got timeout want idle"); end
    get_word(w);
    checks++; if (w !== {32'hD4D3D2D1, 4'hF}) begin errors++; $display("FAIL rstmid_word: got %h want %h", w, {32'hD4D3D2D1, 4'hF}); end
    checks++; if (got_q.size() != got_idx) begin errors++; $display("FAIL rstmid_extra: got %0d extra want 0", got_q.size() - got_idx); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_partial_flush();
    test_empty_flush();
    test_empty_gaps();
    test_flush_on_last();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got stuck simulation want completion");
    $fatal(1, "watchdog");
  end
endmodule
